// File: rtl/soc_system_sysid_checker.sv
// Avalon-MM sysid checker: reads the ID word (and optionally the build timestamp) and compares them.
// Optional timestamp check is enabled by defining SYSID_CHECK_TS_EN.
module soc_system_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID = 32'hACD5_1302,
   parameter logic [31:0] EXPECTED_TS = 32'h55D7_EB21,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        address,
   output logic        read,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

`ifdef SYSID_CHECK_TS_EN
   typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, RD_ID, DONE} state_t;
`endif

   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);

   state_t      state;
   state_t      state_next;
   logic        auto_start;
   logic [15:0] wait_cnt;
   logic        accept;
   logic        expire;

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      expire     = 1'b0;
      case (state)
         IDLE: begin
            if (start || auto_start) state_next = RD_ID;
         end
         RD_ID: begin
            if (!waitrequest) begin
               accept = 1'b1;
`ifdef SYSID_CHECK_TS_EN
               state_next = RD_TS;
`else
               state_next = DONE;
`endif
            end else if (wait_cnt == WAIT_LAST) begin
               expire     = 1'b1;
               state_next = DONE;
            end
         end
`ifdef SYSID_CHECK_TS_EN
         RD_TS: begin
            if (!waitrequest) begin
               accept     = 1'b1;
               state_next = DONE;
            end else if (wait_cnt == WAIT_LAST) begin
               expire     = 1'b1;
               state_next = DONE;
            end
         end
`endif
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs decode straight from the state, so read/address stay put across stalls.
   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
`ifdef SYSID_CHECK_TS_EN
      read    = (state == RD_ID) || (state == RD_TS);
      address = (state == RD_TS);
`else
      read    = (state == RD_ID);
      address = 1'b0;
`endif
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= IDLE;
         auto_start <= 1'b1;
         wait_cnt   <= 16'd0;
         id_ok      <= 1'b0;
         ts_ok      <= 1'b0;
         timeout    <= 1'b0;
         id_value   <= 32'd0;
         ts_value   <= 32'd0;
      end else begin
         state <= state_next;
         if (state_next != state) begin
            wait_cnt <= 16'd0;
         end else if (read && waitrequest) begin
            wait_cnt <= wait_cnt + 16'd1;
         end
         if (state == IDLE && state_next == RD_ID) begin
            auto_start <= 1'b0;
            id_ok      <= 1'b0;
            ts_ok      <= 1'b0;
            timeout    <= 1'b0;
            id_value   <= 32'd0;
            ts_value   <= 32'd0;
         end
         if (expire) timeout <= 1'b1;
         if (accept && state == RD_ID) begin
            id_value <= readdata;
            id_ok    <= (readdata == EXPECTED_ID);
`ifndef SYSID_CHECK_TS_EN
            ts_ok    <= (readdata == EXPECTED_ID);
`endif
         end
`ifdef SYSID_CHECK_TS_EN
         if (accept && state == RD_TS) begin
            ts_value <= readdata;
            ts_ok    <= (readdata == EXPECTED_TS);
         end
`endif
      end
   end

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Randomized self-checking bench for soc_system_sysid_checker against a per-check outcome model.
// Honours SYSID_CHECK_TS_EN the same way the design does.
module tb_soc_system_sysid_checker;

   localparam logic [31:0] EXP_ID = 32'hACD5_1302;
   localparam logic [31:0] EXP_TS = 32'h55D7_EB21;
   localparam int          TO     = 6;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic        address;
   logic        read;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        busy;
   logic        done;
   logic        id_ok;
   logic        ts_ok;
   logic        timeout;
   logic [31:0] id_value;
   logic [31:0] ts_value;

   int          checks = 0;
   int          failures = 0;
   int          stall [2];
   logic [31:0] data [2];
   int          rd_cycles [2];
   int          seen;
   logic        prev_read;
   logic        prev_addr;

   always #5 clock = ~clock;

   soc_system_sysid_checker #(
      .EXPECTED_ID (EXP_ID),
      .EXPECTED_TS (EXP_TS),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .address     (address),
      .read        (read),
      .waitrequest (waitrequest),
      .readdata    (readdata),
      .busy        (busy),
      .done        (done),
      .id_ok       (id_ok),
      .ts_ok       (ts_ok),
      .timeout     (timeout),
      .id_value    (id_value),
      .ts_value    (ts_value)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
      end
   endtask

   // Slave: stalls the first stall[addr] cycles of each read at an address, then returns data[addr].
   initial begin
      seen        = 0;
      prev_read   = 1'b0;
      prev_addr   = 1'b0;
      waitrequest = 1'b0;
      readdata    = 32'd0;
      forever begin
         @(negedge clock);
         if (read === 1'b1) begin
            if (!prev_read || address !== prev_addr) seen = 0;
            rd_cycles[address] = rd_cycles[address] + 1;
            waitrequest = (seen < stall[address]);
            readdata    = waitrequest ? $urandom : data[address];
            if (waitrequest) seen++;
         end else begin
            waitrequest = 1'b0;
         end
         prev_read = (read === 1'b1);
         prev_addr = address;
      end
   end

   task automatic applyStimulus(input bit auto_go, input int s_id, input logic [31:0] d_id,
                                input int s_ts, input logic [31:0] d_ts);
      int          e_lat, e_rd0, e_rd1, cyc;
      logic        e_to, e_idok, e_tsok;
      logic [31:0] e_idv, e_tsv;
      bit          got;
      e_to = 0; e_idok = 0; e_tsok = 0; e_idv = 0; e_tsv = 0; e_rd1 = 0;
      if (s_id >= TO) begin
         e_to = 1; e_rd0 = TO; e_lat = TO + 1;
      end else begin
         e_rd0  = s_id + 1;
         e_idv  = d_id;
         e_idok = (d_id == EXP_ID);
`ifdef SYSID_CHECK_TS_EN
         if (s_ts >= TO) begin
            e_to = 1; e_rd1 = TO; e_lat = e_rd0 + TO + 1;
         end else begin
            e_rd1  = s_ts + 1;
            e_tsv  = d_ts;
            e_tsok = (d_ts == EXP_TS);
            e_lat  = e_rd0 + e_rd1 + 1;
         end
`else
         e_tsok = e_idok;
         e_lat  = e_rd0 + 1;
`endif
      end
      stall[0] = s_id; stall[1] = s_ts;
      data[0]  = d_id; data[1]  = d_ts;
      @(negedge clock);
      rd_cycles[0] = 0; rd_cycles[1] = 0;
      if (auto_go) reset_n = 1'b1;
      else start = 1'b1;
      cyc = 0; got = 0;
      // A start during the check and another in the DONE cycle must both be dropped.
      while (!got && cyc < 300) begin
         @(negedge clock);
         cyc++;
         if (done === 1'b1) begin
            got   = 1;
            start = 1'b1;
         end else begin
            start = (cyc == 2);
         end
      end
      checkOutput("done_latency", 32'(cyc), 32'(e_lat));
      checkOutput("timeout", timeout, e_to);
      checkOutput("id_ok", id_ok, e_idok);
      checkOutput("ts_ok", ts_ok, e_tsok);
      checkOutput("id_value", id_value, e_idv);
      checkOutput("ts_value", ts_value, e_tsv);
      checkOutput("rd_cycles_id", 32'(rd_cycles[0]), 32'(e_rd0));
      checkOutput("rd_cycles_ts", 32'(rd_cycles[1]), 32'(e_rd1));
      @(negedge clock);
      start = 1'b0;
      checkOutput("busy_after", busy, 1'b0);
      checkOutput("done_once", done, 1'b0);
   endtask

   initial begin
      int s_id, s_ts;
      logic [31:0] d_id, d_ts;
      reset_n = 1'b0;
      start   = 1'b0;
      stall[0] = 0; stall[1] = 0;
      data[0] = EXP_ID; data[1] = EXP_TS;
      rd_cycles[0] = 0; rd_cycles[1] = 0;
      repeat (3) @(negedge clock);
      checkOutput("reset_ctrl", {25'd0, read, address, busy, done, id_ok, ts_ok, timeout}, 32'd0);
      checkOutput("reset_id_value", id_value, 32'd0);
      checkOutput("reset_ts_value", ts_value, 32'd0);

      applyStimulus(1, 0, EXP_ID, 0, EXP_TS);
      applyStimulus(0, 0, 32'h1234_5678, 0, EXP_TS);
      applyStimulus(0, 3, EXP_ID, 3, EXP_TS);
      applyStimulus(0, TO, EXP_ID, 0, EXP_TS);
      applyStimulus(0, 0, EXP_ID, TO + 2, EXP_TS);
      applyStimulus(0, TO - 1, EXP_ID, TO - 1, 32'hDEAD_BEEF);

      // Reset in the middle of a check: everything clears, no done, then an automatic rerun.
`ifdef SYSID_CHECK_TS_EN
      stall[0] = 0; stall[1] = 4;
`else
      stall[0] = 4; stall[1] = 0;
`endif
      data[0] = EXP_ID; data[1] = EXP_TS;
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      checkOutput("midreset_busy_before", busy, 1'b1);
      reset_n = 1'b0;
      @(negedge clock);
      checkOutput("midreset_ctrl", {25'd0, read, address, busy, done, id_ok, ts_ok, timeout}, 32'd0);
      checkOutput("midreset_id_value", id_value, 32'd0);
      checkOutput("midreset_ts_value", ts_value, 32'd0);
      @(negedge clock);
      checkOutput("midreset_no_done", done, 1'b0);
      applyStimulus(1, 0, EXP_ID, 0, EXP_TS);

      for (int n = 0; n < 24; n++) begin
         s_id = ($urandom_range(0, 3) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1);
         s_ts = ($urandom_range(0, 3) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1);
         d_id = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom;
         d_ts = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom;
         applyStimulus(0, s_id, d_id, s_ts, d_ts);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
